// File: rtl/gb_serial_link_pkg.sv
// Shared constants and types for the Game Boy serial link (SB/SC registers).
// Optional feature macro: GB_SERIAL_FAST_CLK_EN (CGB double-speed serial bit SC[1]).
package gb_serial_link_pkg;

  localparam int unsigned SER_HALF_PERIOD_DEF = 256;
  localparam int unsigned CNT_W_DEF           = 9;

  // IO register addresses
  localparam logic [15:0] ADDR_SB = 16'hFF01;
  localparam logic [15:0] ADDR_SC = 16'hFF02;

  // Transfer FSM encodings
  localparam int unsigned ST_W    = 2;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_LOW  = 2'd1;
  localparam logic [1:0]  ST_HIGH = 2'd2;
  localparam logic [1:0]  ST_DONE = 2'd3;

  // SC bit positions
  localparam int unsigned SC_START_BIT = 7;
  localparam int unsigned SC_CLK_BIT   = 0;
`ifdef GB_SERIAL_FAST_CLK_EN
  localparam int unsigned SC_SPEED_BIT = 1;
  localparam int unsigned FAST_SHIFT   = 5;
`endif

  localparam int unsigned BIT_CNT_W     = 4;
  localparam logic [3:0]  BITS_PER_XFER = 4'd8;

  // Architecturally visible SC fields
  typedef struct packed {
    logic start;
    logic speed;
    logic int_clk;
  } sc_t;

  // SC read image; unimplemented bits read as 1
  function automatic logic [7:0] sc_read_value(sc_t sc);
    return {sc.start, 5'b11111, sc.speed, sc.int_clk};
  endfunction

endpackage

// File: rtl/gb_serial_link_if.sv
// IO register bus control signals (address and active-low strobes).
interface gb_serial_link_if;

  logic [15:0] addr;
  logic        we_l;
  logic        re_l;

  modport master (output addr, output we_l, output re_l);
  modport slave  (input addr, input we_l, input re_l);

endinterface

// File: rtl/gb_serial_link_clkgen.sv
// Serial clock helper: half-period divider for internal clocking and a
// synchroniser with registered edge strobes for the external serial clock.
module gb_serial_link_clkgen #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] tc_val_i,
  input  logic             ser_clk_i,
  output logic             tc_stb_o,
  output logic             fall_stb_o,
  output logic             rise_stb_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             fall_q, fall_d, rise_q, rise_d;

  // Divider next state; the strobe is registered so it lines up with the count it flags
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!run_i || clr_i || tc_q) begin
      cnt_d = '0;
    end
    tc_d   = run_i && (cnt_d == tc_val_i);
    fall_d = prev_q & ~sync2_q;
    rise_d = ~prev_q & sync2_q;
  end

  // Divider, synchroniser (idles high like the serial clock) and strobe registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      sync1_q <= ser_clk_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fall_q  <= fall_d;
      rise_q  <= rise_d;
    end
  end

  assign tc_stb_o   = tc_q;
  assign fall_stb_o = fall_q;
  assign rise_stb_o = rise_q;

endmodule

// File: rtl/gb_serial_link.sv
// Game Boy serial port: SB (FF01) / SC (FF02) on the IO bus, 8-bit shift
// transfer on an internal or external serial clock, one-cycle completion IRQ.
// Optional feature macro: GB_SERIAL_FAST_CLK_EN (SC[1] speed bit, half period / 32).
module gb_serial_link
  import gb_serial_link_pkg::*;
#(
  parameter int unsigned SER_HALF_PERIOD = SER_HALF_PERIOD_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  gb_serial_link_if.slave   ioreg,
  inout  wire  [7:0]        ioreg_data_io,
  input  logic              ser_clk_in_i,
  input  logic              ser_data_in_i,
  output logic              ser_clk_out_o,
  output logic              ser_clk_oe_o,
  output logic              ser_data_out_o,
  output logic              serial_int_o
);

  localparam logic [CNT_W-1:0] TC_NORM = CNT_W'(SER_HALF_PERIOD - 1);
`ifdef GB_SERIAL_FAST_CLK_EN
  localparam logic [CNT_W-1:0] TC_FAST = CNT_W'((SER_HALF_PERIOD >> FAST_SHIFT) - 1);
`endif

  logic [ST_W-1:0]      state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           sb_q, sb_d;
  logic                 sc_start_q, sc_start_d;
  logic                 sc_clk_q, sc_clk_d;
  logic                 src_int_q, src_int_d;
  logic                 sout_q, sout_d;
  logic                 clk_out_q, clk_out_d;
  logic                 oe_q, oe_d;
  logic                 int_q, int_d;

  logic                 speed_c;
  logic [CNT_W-1:0]     tc_val_c;
  logic                 wr_sb_c, wr_sc_c, rd_hit_c, start_c, run_c;
  logic                 tc_stb_c, fall_stb_c, rise_stb_c;
  logic [7:0]           wdata_c, rdata_c;
  sc_t                  sc_view_c;

`ifdef GB_SERIAL_FAST_CLK_EN
  logic speed_q, speed_d;
  logic fast_q, fast_d;

  // Speed bit and the speed latched at transfer start
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      speed_q <= 1'b0;
      fast_q  <= 1'b0;
    end else begin
      speed_q <= speed_d;
      fast_q  <= fast_d;
    end
  end

  assign speed_c  = speed_q;
  assign tc_val_c = fast_q ? TC_FAST : TC_NORM;
`else
  assign speed_c  = 1'b1;
  assign tc_val_c = TC_NORM;
`endif

  // IO bus decode; reads are combinational and only drive on a matching read
  assign wdata_c   = ioreg_data_io;
  assign wr_sb_c   = !ioreg.we_l && (ioreg.addr == ADDR_SB);
  assign wr_sc_c   = !ioreg.we_l && (ioreg.addr == ADDR_SC);
  assign rd_hit_c  = !ioreg.re_l && ((ioreg.addr == ADDR_SB) || (ioreg.addr == ADDR_SC));
  assign sc_view_c = '{start: sc_start_q, speed: speed_c, int_clk: sc_clk_q};
  assign rdata_c   = (ioreg.addr == ADDR_SB) ? sb_q : sc_read_value(sc_view_c);
  assign ioreg_data_io = rd_hit_c ? rdata_c : 8'hzz;

  assign start_c = wr_sc_c && wdata_c[SC_START_BIT];
  assign run_c   = src_int_q && ((state_q == ST_LOW) || (state_q == ST_HIGH));

  gb_serial_link_clkgen #(
    .CNT_W (CNT_W)
  ) u_clkgen (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .run_i      (run_c),
    .clr_i      (start_c),
    .tc_val_i   (tc_val_c),
    .ser_clk_i  (ser_clk_in_i),
    .tc_stb_o   (tc_stb_c),
    .fall_stb_o (fall_stb_c),
    .rise_stb_o (rise_stb_c)
  );

  // Transfer FSM next state, register writes and registered pin values
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sb_d       = sb_q;
    sc_start_d = sc_start_q;
    sc_clk_d   = sc_clk_q;
    src_int_d  = src_int_q;
    sout_d     = sout_q;
`ifdef GB_SERIAL_FAST_CLK_EN
    speed_d    = speed_q;
    fast_d     = fast_q;
`endif

    case (state_q)
      ST_LOW: begin
        if (src_int_q ? tc_stb_c : rise_stb_c) begin
          state_d   = ST_HIGH;
          sb_d      = {sb_q[6:0], ser_data_in_i};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      ST_HIGH: begin
        // External clock ends right after the 8th shift; internal waits out the half
        if (src_int_q ? tc_stb_c : (fall_stb_c || (bit_cnt_q == BITS_PER_XFER))) begin
          if (bit_cnt_q == BITS_PER_XFER) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOW;
            sout_d  = sb_q[7];
          end
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        sc_start_d = 1'b0;
      end
      default: ;
    endcase

    if (wr_sb_c && (state_q == ST_IDLE)) begin
      sb_d = wdata_c;
    end

    // SC writes override the FSM: start/restart or abort
    if (wr_sc_c) begin
      sc_clk_d = wdata_c[SC_CLK_BIT];
`ifdef GB_SERIAL_FAST_CLK_EN
      speed_d  = wdata_c[SC_SPEED_BIT];
`endif
      if (wdata_c[SC_START_BIT]) begin
        sc_start_d = 1'b1;
        state_d    = ST_LOW;
        bit_cnt_d  = '0;
        sb_d       = sb_q;
        sout_d     = sb_q[7];
        src_int_d  = wdata_c[SC_CLK_BIT];
`ifdef GB_SERIAL_FAST_CLK_EN
        fast_d     = wdata_c[SC_SPEED_BIT];
`endif
      end else begin
        sc_start_d = 1'b0;
        if (state_q != ST_IDLE) begin
          state_d = ST_IDLE;
          sout_d  = 1'b1;
        end
      end
    end

    if (state_d == ST_DONE) begin
      sout_d = 1'b1;
    end
    clk_out_d = !(src_int_d && (state_d == ST_LOW));
    oe_d      = src_int_d && ((state_d == ST_LOW) || (state_d == ST_HIGH));
    int_d     = (state_d == ST_DONE);
  end

  // State, registers and output pins
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      sb_q       <= 8'h00;
      sc_start_q <= 1'b0;
      sc_clk_q   <= 1'b0;
      src_int_q  <= 1'b0;
      sout_q     <= 1'b1;
      clk_out_q  <= 1'b1;
      oe_q       <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sb_q       <= sb_d;
      sc_start_q <= sc_start_d;
      sc_clk_q   <= sc_clk_d;
      src_int_q  <= src_int_d;
      sout_q     <= sout_d;
      clk_out_q  <= clk_out_d;
      oe_q       <= oe_d;
      int_q      <= int_d;
    end
  end

  assign ser_clk_out_o  = clk_out_q;
  assign ser_clk_oe_o   = oe_q;
  assign ser_data_out_o = sout_q;
  assign serial_int_o   = int_q;

endmodule

// File: tb/tb_gb_serial_link.sv
// Self-checking bench for gb_serial_link (default 256-cycle half period).
`timescale 1ns/1ps
module tb_gb_serial_link;

  localparam logic [15:0] A_SB = 16'hFF01;
  localparam logic [15:0] A_SC = 16'hFF02;
`ifdef GB_SERIAL_FAST_CLK_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gb_serial_link_if bus();
  wire  [7:0] ioreg_data;
  logic       tb_oe;
  logic [7:0] tb_wdata;
  assign ioreg_data = tb_oe ? tb_wdata : 8'hzz;

  logic ser_clk_in, ser_din;
  logic ser_clk_out, ser_clk_oe, ser_dout, ser_int;

  int n_cmp = 0;
  int n_bad = 0;

  gb_serial_link dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .ioreg          (bus),
    .ioreg_data_io  (ioreg_data),
    .ser_clk_in_i   (ser_clk_in),
    .ser_data_in_i  (ser_din),
    .ser_clk_out_o  (ser_clk_out),
    .ser_clk_oe_o   (ser_clk_oe),
    .ser_data_out_o (ser_dout),
    .serial_int_o   (ser_int)
  );

  // Expected SC read image from the register rules
  function automatic logic [7:0] sc_expect(input logic start, input logic speed, input logic clk_sel);
    logic [7:0] v;
    v = {start, 6'b111111, clk_sel};
    if (FAST_EN) v[1] = speed;
    return v;
  endfunction

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr = a; tb_wdata = d; tb_oe = 1'b1; bus.we_l = 1'b0;
    @(negedge clk);
    bus.we_l = 1'b1; tb_oe = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus.addr = a; bus.re_l = 1'b0;
    #1 d = ioreg_data;
    bus.re_l = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(A_SB, v);
    n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL reset_sb: got %h expected 00", v); end
    rd(A_SC, v);
    n_cmp++; if (v !== sc_expect(1'b0, 1'b0, 1'b0)) begin n_bad++; $display("FAIL reset_sc: got %h expected %h", v, sc_expect(1'b0, 1'b0, 1'b0)); end
    n_cmp++;
    if ({ser_clk_out, ser_clk_oe, ser_dout, ser_int} !== 4'b1010) begin
      n_bad++; $display("FAIL reset_pins: got %b expected 1010", {ser_clk_out, ser_clk_oe, ser_dout, ser_int});
    end
  endtask

  // Internal-clock transfer of sb0 checked against the bit timeline: half h lasts hl cycles,
  // SOUT carries sb0 MSB-first one bit per two halves, completion at 16*hl, idle at 16*hl+1.
  task automatic run_internal(input logic [7:0] sb0, input bit rand_sin, input bit fast);
    int hl, total, ints, h;
    logic [7:0] exp_sb, v;
    hl = fast ? 8 : 256;
    total = 16 * hl;
    ints = 0;
    exp_sb = 8'h00;
    wr(A_SC, fast ? 8'h83 : 8'h81);
    for (int n = 0; n <= total + 1; n++) begin
      if (n < total && (n % hl) == hl / 2) begin
        h = n / hl;
        if ((h % 2) == 0) begin
          ser_din = rand_sin ? 1'($urandom_range(0, 1)) : 1'b1;
          exp_sb = {exp_sb[6:0], ser_din};
        end
        n_cmp++;
        if (ser_dout !== sb0[7 - h / 2]) begin
          n_bad++; $display("FAIL int_sout half %0d: got %b expected %b", h, ser_dout, sb0[7 - h / 2]);
        end
        n_cmp++;
        if (ser_clk_out !== 1'(h % 2) || ser_clk_oe !== 1'b1) begin
          n_bad++; $display("FAIL int_clk half %0d: got clk=%b oe=%b expected clk=%0d oe=1", h, ser_clk_out, ser_clk_oe, h % 2);
        end
      end
      if (n == total) begin
        n_cmp++;
        if ({ser_int, ser_dout, ser_clk_out, ser_clk_oe} !== 4'b1110) begin
          n_bad++; $display("FAIL int_done_pins: got %b expected 1110", {ser_int, ser_dout, ser_clk_out, ser_clk_oe});
        end
        rd(A_SC, v);
        n_cmp++; if (v !== sc_expect(1'b1, fast, 1'b1)) begin n_bad++; $display("FAIL int_sc_busy: got %h expected %h", v, sc_expect(1'b1, fast, 1'b1)); end
      end
      if (n == total + 1) begin
        rd(A_SC, v);
        n_cmp++; if (v !== sc_expect(1'b0, fast, 1'b1)) begin n_bad++; $display("FAIL int_sc_end: got %h expected %h", v, sc_expect(1'b0, fast, 1'b1)); end
        rd(A_SB, v);
        n_cmp++; if (v !== exp_sb) begin n_bad++; $display("FAIL int_sb_end: got %h expected %h", v, exp_sb); end
      end
      ints += int'(ser_int);
      @(negedge clk);
    end
    n_cmp++; if (ints != 1) begin n_bad++; $display("FAIL int_irq_count: got %0d expected 1", ints); end
  endtask

  task automatic test_internal();
    logic [7:0] sb;
    wr(A_SB, 8'hA5);
    run_internal(8'hA5, 1'b0, 1'b0);
    sb = 8'($urandom);
    wr(A_SB, sb);
    run_internal(sb, 1'b1, 1'b0);
  endtask

  task automatic test_external(input logic [7:0] sb0, input logic [7:0] sin_byte);
    int ints;
    logic [7:0] v;
    ints = 0;
    wr(A_SB, sb0);
    wr(A_SC, 8'h80);
    repeat (20) begin @(negedge clk); ints += int'(ser_int); end
    rd(A_SC, v);
    n_cmp++; if (v !== sc_expect(1'b1, 1'b0, 1'b0)) begin n_bad++; $display("FAIL ext_waiting_sc: got %h expected %h", v, sc_expect(1'b1, 1'b0, 1'b0)); end
    n_cmp++;
    if (ints != 0 || ser_clk_oe !== 1'b0 || ser_clk_out !== 1'b1) begin
      n_bad++; $display("FAIL ext_idle: got ints=%0d oe=%b clk=%b expected 0 0 1", ints, ser_clk_oe, ser_clk_out);
    end
    for (int j = 0; j < 8; j++) begin
      ser_clk_in = 1'b0;
      ser_din = sin_byte[7 - j];
      repeat (8) begin @(negedge clk); ints += int'(ser_int); end
      n_cmp++;
      if (ser_dout !== sb0[7 - j]) begin n_bad++; $display("FAIL ext_sout bit %0d: got %b expected %b", j, ser_dout, sb0[7 - j]); end
      ser_clk_in = 1'b1;
      repeat (8) begin @(negedge clk); ints += int'(ser_int); end
    end
    n_cmp++; if (ints != 1) begin n_bad++; $display("FAIL ext_irq_count: got %0d expected 1", ints); end
    rd(A_SB, v);
    n_cmp++; if (v !== sin_byte) begin n_bad++; $display("FAIL ext_sb: got %h expected %h", v, sin_byte); end
    rd(A_SC, v);
    n_cmp++; if (v !== sc_expect(1'b0, 1'b0, 1'b0)) begin n_bad++; $display("FAIL ext_sc_end: got %h expected %h", v, sc_expect(1'b0, 1'b0, 1'b0)); end
  endtask

  task automatic test_abort();
    logic [7:0] sb0, v, nsb;
    logic s;
    int ints, bad_pins;
    sb0 = 8'($urandom);
    s = 1'($urandom_range(0, 1));
    ser_din = s;
    wr(A_SB, sb0);
    wr(A_SC, 8'h81);
    repeat (1600) @(negedge clk);
    wr(A_SC, 8'h01);
    ints = 0; bad_pins = 0;
    repeat (600) begin
      @(negedge clk);
      ints += int'(ser_int);
      if (ser_clk_out !== 1'b1 || ser_clk_oe !== 1'b0) bad_pins++;
    end
    n_cmp++; if (ints != 0) begin n_bad++; $display("FAIL abort_irq: got %0d expected 0", ints); end
    n_cmp++; if (bad_pins != 0) begin n_bad++; $display("FAIL abort_clk_pins: got %0d bad cycles expected 0", bad_pins); end
    rd(A_SC, v);
    n_cmp++; if (v !== sc_expect(1'b0, 1'b0, 1'b1)) begin n_bad++; $display("FAIL abort_sc: got %h expected %h", v, sc_expect(1'b0, 1'b0, 1'b1)); end
    rd(A_SB, v);
    n_cmp++; if (v !== {sb0[4:0], s, s, s}) begin n_bad++; $display("FAIL abort_partial_sb: got %h expected %h", v, {sb0[4:0], s, s, s}); end
    nsb = 8'($urandom);
    wr(A_SB, nsb);
    rd(A_SB, v);
    n_cmp++; if (v !== nsb) begin n_bad++; $display("FAIL abort_sb_write: got %h expected %h", v, nsb); end
  endtask

  task automatic test_restart();
    logic [7:0] sb0, v, partial;
    logic s;
    sb0 = 8'($urandom);
    s = 1'($urandom_range(0, 1));
    ser_din = s;
    wr(A_SB, sb0);
    wr(A_SC, 8'h81);
    repeat (600) @(negedge clk);
    wr(A_SB, ~sb0);
    partial = {sb0[6:0], s};
    rd(A_SB, v);
    n_cmp++; if (v !== partial) begin n_bad++; $display("FAIL busy_sb_write_ignored: got %h expected %h", v, partial); end
    run_internal(partial, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    wr(A_SB, 8'($urandom));
    wr(A_SC, 8'h81);
    repeat (1100) @(negedge clk);
    n_cmp++;
    if (ser_clk_out !== 1'b0 || ser_clk_oe !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_active: got clk=%b oe=%b expected 0 1", ser_clk_out, ser_clk_oe);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ser_clk_out, ser_clk_oe, ser_dout, ser_int} !== 4'b1010) begin
      n_bad++; $display("FAIL async_reset_pins: got %b expected 1010", {ser_clk_out, ser_clk_oe, ser_dout, ser_int});
    end
    rd(A_SC, v);
    n_cmp++; if (v !== sc_expect(1'b0, 1'b0, 1'b0)) begin n_bad++; $display("FAIL async_reset_sc: got %h expected %h", v, sc_expect(1'b0, 1'b0, 1'b0)); end
    rd(A_SB, v);
    n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL async_reset_sb: got %h expected 00", v); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef GB_SERIAL_FAST_CLK_EN
  task automatic test_fast();
    logic [7:0] sb;
    sb = 8'($urandom);
    wr(A_SB, sb);
    run_internal(sb, 1'b1, 1'b1);
  endtask
`endif

  initial begin
    bus.addr = 16'h0000; bus.we_l = 1'b1; bus.re_l = 1'b1;
    tb_oe = 1'b0; tb_wdata = 8'h00;
    ser_clk_in = 1'b1; ser_din = 1'b1;
    test_reset();
    test_internal();
    test_external(8'h3C, 8'h5A);
    test_external(8'($urandom), 8'($urandom));
    test_abort();
    test_restart();
    test_async_reset();
`ifdef GB_SERIAL_FAST_CLK_EN
    test_fast();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
